fetch_ctrl: RTL

//   Sequencer for the synchronous-read instruction memory (1-cycle read latency, read-only).
//   - Owns the PC and drives the word address into the imem.
//   - Aligns each returned word with its PC.
//   - Presents instructions to decode over a valid/ready handshake.
//   - Applies branch/jump redirects from execute and flags misaligned targets.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    localparam int INSN_BYTES = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch sequencer for a 1-cycle-latency instruction memory: owns the PC, aligns read data with it,
// hands instructions to decode over valid/ready and applies redirects. Optional FETCH_PERF_EN adds counters.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned DEPTH    = 256,
    localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rd_data,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_ins,
    output logic              if_fault
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam logic [31:0] PC_STEP = 32'(INSN_BYTES);

    logic [31:0]       req_pc_q, req_pc_d;
    logic [31:0]       rsp_pc_q, rsp_pc_d;
    logic              rsp_vld_q, rsp_vld_d;
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] sel_addr;
    logic              redir_ok, redir_bad, stall;

    assign redir_ok  = redirect_valid & (redirect_pc[1:0] == 2'b00);
    assign redir_bad = redirect_valid & (redirect_pc[1:0] != 2'b00);
    assign stall     = rsp_vld_q & ~if_ready;

    always_comb begin
        sel_addr  = req_pc_q[ADDR_W+1:2];
        req_pc_d  = req_pc_q;
        rsp_pc_d  = rsp_pc_q;
        rsp_vld_d = rsp_vld_q;
        state_d   = state_q;
        if (redir_ok) begin
            sel_addr  = redirect_pc[ADDR_W+1:2];
            rsp_pc_d  = redirect_pc;
            rsp_vld_d = 1'b1;
            req_pc_d  = redirect_pc + PC_STEP;
            state_d   = RUN;
        end else if (redir_bad) begin
            state_d   = FAULT;
            rsp_vld_d = 1'b0;
        end else if (state_q != FAULT) begin
            if (stall) begin
                // Re-read the displayed word so imem_rd_data stays put while decode stalls.
                sel_addr = rsp_pc_q[ADDR_W+1:2];
            end else begin
                rsp_pc_d  = req_pc_q;
                rsp_vld_d = 1'b1;
                req_pc_d  = req_pc_q + PC_STEP;
                state_d   = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_pc_q  <= RESET_PC;
            rsp_pc_q  <= RESET_PC;
            rsp_vld_q <= 1'b0;
            state_q   <= BOOT;
        end else begin
            req_pc_q  <= req_pc_d;
            rsp_pc_q  <= rsp_pc_d;
            rsp_vld_q <= rsp_vld_d;
            state_q   <= state_d;
        end
    end

    assign imem_addr = sel_addr;
    assign if_valid  = rsp_vld_q & ~redirect_valid & (state_q == RUN);
    assign if_pc     = rsp_pc_q;
    assign if_ins    = imem_rd_data;
    assign if_fault  = (state_q == FAULT);

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (if_valid & if_ready)  perf_fetch_q <= perf_fetch_q + 32'd1;
            if (if_valid & ~if_ready) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
